// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and address helpers for the load/store unit.
// Combinational helpers only; no state.
package lsu_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
    } lsu_ctrl_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word.
    function automatic logic lane_fault(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

    function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return {lo[1], 1'b0};
            2'b10:   return 2'b00;
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Core-side request/response and data_mem port bundle for the load/store unit.
// slave = LSU view; master = core plus memory view.
interface lsu_mem_port_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     req;
    logic                     we;
    logic [2:0]               funct3;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     mem_write_en;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_data_in;
    logic [DATA_WIDTH-1:0]    mem_data_out;

    modport slave (
        input  req, we, funct3, addr, wdata, mem_data_out,
        output busy, done, err, rdata, mem_write_en, mem_addr, mem_data_in
    );

    modport master (
        output req, we, funct3, addr, wdata, mem_data_out,
        input  busy, done, err, rdata, mem_write_en, mem_addr, mem_data_in
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module lsu_lane_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  offs,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);
    import lsu_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offs, 3'b000} +: 8];
        half_sel = offs[1] ? word[31:16] : word[15:0];

        load_val = '0;
        case (funct3)
            F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_val = word;
            F3_BU:   load_val = {24'h0, byte_sel};
            F3_HU:   load_val = {16'h0, half_sel};
            default: load_val = '0;
        endcase

        merged = word;
        case (funct3)
            F3_B: merged[{offs, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (offs[1])
                    merged[31:16] = wdata;
                else
                    merged[15:0]  = wdata;
            end
            default: merged = word;
        endcase
    end
endmodule

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit driving a word-wide data_mem; sub-word stores via read-modify-write.
// Latency req->done: load/SW 2, SB/SH 3, error 1. MISALIGN_TRAP_EN makes misaligned H/W accesses error.
// Backpressure: one transaction in flight; req is ignored while busy, nothing is queued.
module lsu_mem_port #(
    parameter int DATA_WIDTH    = lsu_pkg::DATA_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic          clk,
    input  logic          n_clr,
    lsu_mem_port_if.slave bus
);
    import lsu_pkg::*;

    lsu_state_t      state;
    lsu_ctrl_t       ctrl;
    logic [1:0]      off_q;
    logic [15:0]     wdata_lo_q;
    logic [31:0]     load_val;
    logic [31:0]     merged;
    logic            req_fault;
    logic [1:0]      req_offs;

`ifdef MISALIGN_TRAP_EN
    assign req_fault = lane_fault(bus.funct3, bus.addr[1:0]);
    assign req_offs  = bus.addr[1:0];
`else
    // Misaligned accesses silently drop the offending low address bits.
    assign req_fault = 1'b0;
    assign req_offs  = align_lo(bus.funct3, bus.addr[1:0]);
`endif

    lsu_lane_align u_align (
        .funct3   (ctrl.funct3),
        .offs     (off_q),
        .word     (bus.mem_data_out),
        .wdata    (wdata_lo_q),
        .load_val (load_val),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            state            <= ST_IDLE;
            ctrl             <= '0;
            off_q            <= '0;
            wdata_lo_q       <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.err          <= 1'b0;
            bus.rdata        <= '0;
            bus.mem_write_en <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_data_in  <= '0;
        end else begin
            bus.done         <= 1'b0;
            bus.mem_write_en <= 1'b0;
            bus.mem_data_in  <= '0;
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        ctrl       <= '{we: bus.we, funct3: bus.funct3};
                        wdata_lo_q <= bus.wdata[15:0];
                        bus.busy   <= 1'b1;
                        if (!f3_legal(bus.we, bus.funct3) || req_fault) begin
                            state     <= ST_RESP;
                            bus.done  <= 1'b1;
                            bus.err   <= 1'b1;
                            bus.rdata <= '0;
                        end else begin
                            state        <= ST_ACCESS;
                            off_q        <= req_offs;
                            bus.mem_addr <= {bus.addr[ADDRESS_WIDTH-1:2], 2'b00};
                            // A full-word store needs no read, so it writes in ACCESS.
                            if (bus.we && (bus.funct3 == F3_W)) begin
                                bus.mem_write_en <= 1'b1;
                                bus.mem_data_in  <= bus.wdata;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (ctrl.we && (ctrl.funct3 != F3_W)) begin
                        state            <= ST_WRITE;
                        bus.mem_write_en <= 1'b1;
                        bus.mem_data_in  <= merged;
                    end else begin
                        state    <= ST_RESP;
                        bus.done <= 1'b1;
                        bus.err  <= 1'b0;
                        if (!ctrl.we)
                            bus.rdata <= load_val;
                    end
                end
                ST_WRITE: begin
                    state    <= ST_RESP;
                    bus.done <= 1'b1;
                    bus.err  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed vector bench for lsu_mem_port against a small word-addressed memory model.
module tb_lsu_mem_port;
    logic clk;
    logic n_clr;

    lsu_mem_port_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    lsu_mem_port #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
        .clk   (clk),
        .n_clr (n_clr),
        .bus   (bus)
    );

    logic [31:0] mem [64];
    int          wr_total;
    int          n_chk;
    int          n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_data_out = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (bus.mem_write_en) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_data_in;
            wr_total = wr_total + 1;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
        int          wr;
        string       name;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vt [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic we_i, input logic [2:0] f3_i, input logic [31:0] a,
                           input logic [31:0] wd, output int lat, output logic e,
                           output logic [31:0] rd, output int wr);
        int w0;
        w0         = wr_total;
        bus.req    = 1'b1;
        bus.we     = we_i;
        bus.funct3 = f3_i;
        bus.addr   = a;
        bus.wdata  = wd;
        @(posedge clk); #1;
        bus.req = 1'b0;
        lat     = 1;
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.done) lat = -1;
        e  = bus.err;
        rd = bus.rdata;
        @(posedge clk); #1;
        wr = wr_total - w0;
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [31:0] rd;
        int          wr;
        int          ndone;

        n_chk      = 0;
        n_err      = 0;
        wr_total   = 0;
        n_clr      = 1'b0;
        bus.req    = 1'b0;
        bus.we     = 1'b0;
        bus.funct3 = 3'b000;
        bus.addr   = '0;
        bus.wdata  = '0;

        //        we    f3      addr    wdata          lat err  chk  rdata         wr name
        vt[0]  = '{1'b1, 3'b010, 32'd20, 32'h0000000A, 2, 1'b0, 1'b0, 32'h0,        1, "sw20"};
        vt[1]  = '{1'b0, 3'b010, 32'd20, 32'h0,        2, 1'b0, 1'b1, 32'h0000000A, 0, "lw20"};
        vt[2]  = '{1'b1, 3'b010, 32'd24, 32'h11223344, 2, 1'b0, 1'b0, 32'h0,        1, "sw24"};
        vt[3]  = '{1'b1, 3'b000, 32'd25, 32'h000000FF, 3, 1'b0, 1'b0, 32'h0,        1, "sb25"};
        vt[4]  = '{1'b0, 3'b010, 32'd24, 32'h0,        2, 1'b0, 1'b1, 32'h1122FF44, 0, "lw24"};
        vt[5]  = '{1'b1, 3'b010, 32'd0,  32'h8000F0F0, 2, 1'b0, 1'b0, 32'h0,        1, "sw0"};
        vt[6]  = '{1'b0, 3'b000, 32'd1,  32'h0,        2, 1'b0, 1'b1, 32'hFFFFFFF0, 0, "lb1"};
        vt[7]  = '{1'b0, 3'b100, 32'd1,  32'h0,        2, 1'b0, 1'b1, 32'h000000F0, 0, "lbu1"};
        vt[8]  = '{1'b0, 3'b001, 32'd2,  32'h0,        2, 1'b0, 1'b1, 32'hFFFF8000, 0, "lh2"};
        vt[9]  = '{1'b0, 3'b101, 32'd2,  32'h0,        2, 1'b0, 1'b1, 32'h00008000, 0, "lhu2"};
        vt[10] = '{1'b1, 3'b001, 32'd26, 32'h5555ABCD, 3, 1'b0, 1'b0, 32'h0,        1, "sh26"};
        vt[11] = '{1'b0, 3'b010, 32'd24, 32'h0,        2, 1'b0, 1'b1, 32'hABCDFF44, 0, "lw24b"};
        vt[12] = '{1'b0, 3'b001, 32'd26, 32'h0,        2, 1'b0, 1'b1, 32'hFFFFABCD, 0, "lh26"};
        vt[13] = '{1'b0, 3'b000, 32'd3,  32'h0,        2, 1'b0, 1'b1, 32'hFFFFFF80, 0, "lb3"};
        vt[14] = '{1'b0, 3'b011, 32'd20, 32'h0,        1, 1'b1, 1'b1, 32'h0,        0, "ld_f3_011"};
        vt[15] = '{1'b1, 3'b100, 32'd20, 32'hDEADBEEF, 1, 1'b1, 1'b1, 32'h0,        0, "st_f3_100"};
`ifdef MISALIGN_TRAP_EN
        vt[16] = '{1'b0, 3'b010, 32'd22, 32'h0,        1, 1'b1, 1'b1, 32'h0,        0, "lw22"};
        vt[17] = '{1'b0, 3'b001, 32'd3,  32'h0,        1, 1'b1, 1'b1, 32'h0,        0, "lh3"};
`else
        vt[16] = '{1'b0, 3'b010, 32'd22, 32'h0,        2, 1'b0, 1'b1, 32'h0000000A, 0, "lw22"};
        vt[17] = '{1'b0, 3'b001, 32'd3,  32'h0,        2, 1'b0, 1'b1, 32'hFFFF8000, 0, "lh3"};
`endif

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   {31'h0, bus.busy},         32'h0);
        check("rst_done",   {31'h0, bus.done},         32'h0);
        check("rst_err",    {31'h0, bus.err},          32'h0);
        check("rst_rdata",  bus.rdata,                 32'h0);
        check("rst_wen",    {31'h0, bus.mem_write_en}, 32'h0);
        check("rst_maddr",  bus.mem_addr,              32'h0);
        check("rst_mdin",   bus.mem_data_in,           32'h0);
        n_clr = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            run_txn(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, lat, e, rd, wr);
            check({vt[i].name, "_lat"}, lat, vt[i].lat);
            check({vt[i].name, "_err"}, {31'h0, e}, {31'h0, vt[i].err});
            check({vt[i].name, "_wr"}, wr, vt[i].wr);
            if (vt[i].chk_rd)
                check({vt[i].name, "_rdata"}, rd, vt[i].rd);
        end

        // req held through the whole transaction, including the RESP cycle.
        bus.req    = 1'b1;
        bus.we     = 1'b0;
        bus.funct3 = 3'b010;
        bus.addr   = 32'd20;
        ndone      = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c == 0)
                check("hold_busy", {31'h0, bus.busy}, 32'h1);
            if (bus.done) begin
                ndone++;
                check("hold_rdata", bus.rdata, 32'h0000000A);
                @(posedge clk); #1;
                bus.req = 1'b0;
            end
        end
        check("hold_ndone", ndone, 1);
        check("hold_idle", {31'h0, bus.busy}, 32'h0);

        // Reset lands in the WRITE cycle of a byte store.
        run_txn(1'b1, 3'b010, 32'd28, 32'h55667788, lat, e, rd, wr);
        bus.req    = 1'b1;
        bus.we     = 1'b1;
        bus.funct3 = 3'b000;
        bus.addr   = 32'd29;
        bus.wdata  = 32'h00000000;
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        check("wr_state_wen", {31'h0, bus.mem_write_en}, 32'h1);
        n_clr = 1'b0;
        #1;
        check("abort_wen",  {31'h0, bus.mem_write_en}, 32'h0);
        check("abort_busy", {31'h0, bus.busy},         32'h0);
        @(posedge clk); #1;
        n_clr = 1'b1;
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("abort_nodone", ndone, 0);
        run_txn(1'b0, 3'b010, 32'd28, 32'h0, lat, e, rd, wr);
        check("abort_reread", rd, 32'h55667788);
        check("abort_lat", lat, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit sitting between the core's execute stage and `data_mem`; it is the initiator on the memory port (drives `write_en`, `addr`, `data_in`, consumes `data_out`). Converts RV32I byte/halfword/word loads and stores into word accesses: extracts and sign/zero-extends load lanes, and performs read-modify-write for sub-word stores. Core-side req/busy/done handshake; one transaction in flight.

## Interface
Parameters:
- DATA_WIDTH, 32, memory/core data width (only 32 supported)
- ADDRESS_WIDTH, 32, byte address width

Ports:
- clk  in  1  rising-edge clock
- n_clr  in  1  reset, asynchronous, active-low
- req  in  1  transaction request, sampled only in IDLE
- we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I size/sign code
- addr  in  ADDRESS_WIDTH  byte address
- wdata  in  DATA_WIDTH  store data (low lanes used for SB/SH)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, transaction complete
- err  out  1  valid with done; illegal funct3 or misaligned (see Configuration)
- rdata  out  DATA_WIDTH  load result, valid with done, held until next done
- mem_write_en  out  1  to data_mem write_en
- mem_addr  out  ADDRESS_WIDTH  word-aligned byte address ({addr[31:2],2'b00})
- mem_data_in  out  DATA_WIDTH  to data_mem data_in
- mem_data_out  in  DATA_WIDTH  from data_mem, combinational read of mem_addr

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE: req=1 registers we/funct3/addr/wdata → ACCESS; illegal or trapped request → RESP with err=1, no memory activity.
- ACCESS: mem_addr driven. Load: capture lane of mem_data_out, extend, → RESP. SW: mem_write_en=1, mem_data_in=wdata → RESP. SB/SH: register merged word (old word with addressed lane(s) replaced) → WRITE.
- WRITE: mem_write_en=1, mem_data_in=merged word → RESP.
- RESP: done=1 → IDLE.
- Lanes little-endian: byte k = bits [8k+7:8k], k=addr[1:0]; halfword at addr[1] selects [31:16] else [15:0].
- LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
- Legal funct3: loads 000,001,010,100,101; stores 000,001,010. Others → err=1, rdata=0.
- mem_write_en high only in ACCESS (SW) and WRITE (SB/SH); mem_data_in=0, mem_addr held otherwise.
- req while busy ignored (not queued).

## Timing
- Reset (n_clr=0, immediate): state IDLE, busy=0, done=0, err=0, rdata=0, mem_write_en=0, mem_addr=0, mem_data_in=0.
- Reset mid-transaction aborts; write not yet clocked is lost, no done.
- Latency req→done: load 2 cycles, SW 2, SB/SH 3, error 1.
- Back-to-back: new req accepted in cycle after done (IDLE); req in RESP cycle ignored.
- rdata and err update only on transition into RESP.

## Configuration
- MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]≠0 → err=1, no memory access, 1-cycle latency.
- Undefined: misalignment never errors; offending low address bits forced to 0 (halfword clears addr[0], word clears addr[1:0]); err asserts only for illegal funct3.

## Structure
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, DATA_WIDTH default.
- Sub-module lsu_lane_align (combinational): load extract/extend and store merge from funct3, addr[1:0], word, wdata.
- Top holds FSM and registers.

## Test plan
- Reset, SW addr=20 wdata=0x0000000A, then LW addr=20 → done 2 cycles each, rdata=0x0000000A, err=0.
- SW addr=24 wdata=0x11223344; SB addr=25 wdata=0xFF; LW addr=24 → 0x1122FF44; SB done at cycle 3.
- Word 0x8000F0F0 at addr 0: LB addr=1 → 0xFFFFFFF0; LBU addr=1 → 0x000000F0; LH addr=2 → 0xFFFF8000; LHU addr=2 → 0x00008000.
- LW addr=22: with MISALIGN_TRAP_EN → err=1 at 1 cycle, mem_write_en never high; without → reads word at 20, err=0.
- funct3=011 load → err=1, rdata=0; req held high during busy → only one transaction completes.
- Assert n_clr=0 during WRITE of SB → mem_write_en drops immediately, word unchanged on re-read, no done.
